// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant plus encoded index, held until release.
// Define ARB_TIMEOUT_EN to revoke grants after MAX_HOLD cycles and pulse timeout.
module rr_grant_arbiter #(
   parameter int ENCODE_WIDTH = 2,
   parameter int DECODE_WIDTH = 2**ENCODE_WIDTH,
   parameter int MAX_HOLD     = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DECODE_WIDTH-1:0] req,
   output logic [DECODE_WIDTH-1:0] gnt,
   output logic [ENCODE_WIDTH-1:0] gnt_idx,
   output logic                    gnt_valid,
   output logic                    timeout
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   if ((MAX_HOLD < 1) || (DECODE_WIDTH != 2**ENCODE_WIDTH)) begin : g_param_check
      $error("rr_grant_arbiter: MAX_HOLD must be >= 1 and DECODE_WIDTH must be 2**ENCODE_WIDTH");
   end

   logic [0:0]              state;
   logic [ENCODE_WIDTH-1:0] ptr;
   logic [ENCODE_WIDTH-1:0] win;
   logic [ENCODE_WIDTH-1:0] cand;
   logic                    found;
   logic                    held;
   logic                    revoke;
   logic                    done;

   // Circular priority search starting at ptr; index arithmetic wraps naturally.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
         cand = ptr + ENCODE_WIDTH'(i);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign held      = req[gnt_idx];
   assign done      = (state == BUSY) && (!held || revoke);
   assign gnt_valid = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] hold_cnt;

   assign revoke = (state == BUSY) && held && (hold_cnt == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= revoke;
         if (state == IDLE) begin
            hold_cnt <= CNT_W'(found);
         end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign revoke  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state   <= BUSY;
                  gnt     <= DECODE_WIDTH'(1) << win;
                  gnt_idx <= win;
               end
            end
            BUSY: begin
               if (done) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  gnt_idx <= '0;
                  ptr     <= gnt_idx + ENCODE_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
